csr_trap_ctrl: RTL and testbench

CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

---
 rtl/csr_trap_ctrl_pkg.sv | 41 ++++
 rtl/csr_trap_ctrl.sv | 151 +++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/csr_trap_ctrl_pkg.sv
// Shared encodings for the system-op / trap controller: op codes, FSM states,
// mcause values and the latched request payload.
package csr_trap_ctrl_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned IDX_W = 12;
    localparam int unsigned OP_W  = 3;

    typedef enum logic [OP_W-1:0] {
        OP_CSRRW = 3'd0,
        OP_CSRRS = 3'd1,
        OP_CSRRC = 3'd2,
        OP_ECALL = 3'd3,
        OP_MRET  = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CSR_RD = 3'd1,
        S_CSR_WR = 3'd2,
        S_TRAP   = 3'd3,
        S_MRET   = 3'd4,
        S_RESP   = 3'd5
    } state_e;

    localparam logic [XLEN-1:0] MCAUSE_ECALL_M = 64'd11;
    localparam logic [XLEN-1:0] MCAUSE_TIMER   = 64'h8000_0000_0000_0007;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [IDX_W-1:0] idx;
        logic [XLEN-1:0]  src;
        logic             src_zero;
        logic [XLEN-1:0]  pc;
    } req_t;

    function automatic logic is_csr_op(input logic [OP_W-1:0] op);
        return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
    endfunction

endpackage

// File: rtl/csr_trap_ctrl.sv
// Sequences CSR read-modify-write, ECALL, MRET and timer traps between EX and
// the CSR file; emits done/redirect pulses and the CSR access strobes.
module csr_trap_ctrl
    import csr_trap_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OP_W-1:0]  req_op,
    input  logic [IDX_W-1:0] req_idx,
    input  logic [XLEN-1:0]  req_src,
    input  logic             req_src_zero,
    input  logic [XLEN-1:0]  cur_pc,
    input  logic             stall_i,
    output logic             done,
    output logic [XLEN-1:0]  rd_data,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             busy,
    output logic [XLEN-1:0]  csr_pc,
    output logic             csr_rd_en,
    output logic             csr_wr_en,
    output logic [IDX_W-1:0] csr_idx,
    output logic [XLEN-1:0]  wbck_csr_data,
    output logic             cmt_mret_ena,
    output logic             ecall_trap_ena,
    output logic [XLEN-1:0]  trap_mcause_value,
    output logic             csr_ex_stall,
    input  logic             tmr_trap_ena,
    input  logic [XLEN-1:0]  read_csr_data
);

    state_e          state_q, state_d;
    req_t            req_q, req_d;
    logic [XLEN-1:0] old_q, old_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic [XLEN-1:0] rmw_data;
    logic            timer_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            old_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            old_q   <= old_d;
            tgt_q   <= tgt_d;
        end
    end

    // CSR read-modify-write data from the old value and the latched source.
    always_comb begin
        rmw_data = '0;
        case (req_q.op)
            OP_CSRRW: rmw_data = req_q.src;
            OP_CSRRS: rmw_data = old_q | req_q.src;
            OP_CSRRC: rmw_data = old_q & ~req_q.src;
            default:  rmw_data = '0;
        endcase
    end

    assign timer_take = (state_q == S_IDLE) & ~rst & tmr_trap_ena & ~stall_i;

    always_comb begin
        state_d           = state_q;
        req_d             = req_q;
        old_d             = old_q;
        tgt_d             = tgt_q;
        req_ready         = 1'b0;
        done              = 1'b0;
        rd_data           = '0;
        redirect_valid    = 1'b0;
        redirect_pc       = '0;
        busy              = (state_q != S_IDLE);
        csr_pc            = cur_pc;
        csr_rd_en         = 1'b0;
        csr_wr_en         = 1'b0;
        csr_idx           = '0;
        wbck_csr_data     = '0;
        cmt_mret_ena      = 1'b0;
        ecall_trap_ena    = 1'b0;
        trap_mcause_value = '0;
        csr_ex_stall      = stall_i;

        case (state_q)
            S_IDLE: begin
                req_ready = ~rst & ~tmr_trap_ena & ~stall_i;
                // A pending timer interrupt wins over any offered op.
                if (timer_take) begin
                    wbck_csr_data     = cur_pc;
                    trap_mcause_value = MCAUSE_TIMER;
                    tgt_d             = read_csr_data;
                    csr_ex_stall      = 1'b0;
                    state_d           = S_RESP;
                end else if (req_valid && req_ready) begin
                    req_d = '{op: req_op, idx: req_idx, src: req_src,
                              src_zero: req_src_zero, pc: cur_pc};
                    case (req_op)
                        OP_CSRRW, OP_CSRRS, OP_CSRRC: state_d = S_CSR_RD;
                        OP_ECALL:                     state_d = S_TRAP;
                        OP_MRET:                      state_d = S_MRET;
                        default:                      state_d = S_CSR_WR;
                    endcase
                end
            end
            S_CSR_RD: begin
                csr_rd_en = 1'b1;
                csr_idx   = req_q.idx;
                old_d     = read_csr_data;
                state_d   = S_CSR_WR;
            end
            S_CSR_WR: begin
                done    = 1'b1;
                state_d = S_IDLE;
                // Reserved ops land here too and complete without touching the CSRs.
                if (is_csr_op(req_q.op)) begin
                    rd_data       = old_q;
                    csr_idx       = req_q.idx;
                    wbck_csr_data = rmw_data;
                    csr_wr_en     = (req_q.op == OP_CSRRW) | ~req_q.src_zero;
                end
            end
            S_TRAP: begin
                ecall_trap_ena    = 1'b1;
                wbck_csr_data     = req_q.pc;
                trap_mcause_value = MCAUSE_ECALL_M;
                tgt_d             = read_csr_data;
                csr_ex_stall      = 1'b0;
                state_d           = S_RESP;
            end
            S_MRET: begin
                cmt_mret_ena = 1'b1;
                tgt_d        = read_csr_data;
                csr_ex_stall = 1'b0;
                state_d      = S_RESP;
            end
            S_RESP: begin
                redirect_valid = 1'b1;
                redirect_pc    = tgt_q;
                done           = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl: CSR RMW ops, ECALL, MRET, timer priority,
// reserved ops, stall gating and reset mid-operation.
module tb_csr_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_idx;
    logic [63:0] req_src;
    logic        req_src_zero;
    logic [63:0] cur_pc;
    logic        stall_i;
    logic        done;
    logic [63:0] rd_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        busy;
    logic [63:0] csr_pc;
    logic        csr_rd_en;
    logic        csr_wr_en;
    logic [11:0] csr_idx;
    logic [63:0] wbck_csr_data;
    logic        cmt_mret_ena;
    logic        ecall_trap_ena;
    logic [63:0] trap_mcause_value;
    logic        csr_ex_stall;
    logic        tmr_trap_ena;
    logic [63:0] read_csr_data;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    csr_trap_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_op            (req_op),
        .req_idx           (req_idx),
        .req_src           (req_src),
        .req_src_zero      (req_src_zero),
        .cur_pc            (cur_pc),
        .stall_i           (stall_i),
        .done              (done),
        .rd_data           (rd_data),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .busy              (busy),
        .csr_pc            (csr_pc),
        .csr_rd_en         (csr_rd_en),
        .csr_wr_en         (csr_wr_en),
        .csr_idx           (csr_idx),
        .wbck_csr_data     (wbck_csr_data),
        .cmt_mret_ena      (cmt_mret_ena),
        .ecall_trap_ena    (ecall_trap_ena),
        .trap_mcause_value (trap_mcause_value),
        .csr_ex_stall      (csr_ex_stall),
        .tmr_trap_ena      (tmr_trap_ena),
        .read_csr_data     (read_csr_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic offer(input logic [2:0] op, input logic [11:0] idx,
                         input logic [63:0] src, input logic sz, input logic [63:0] pc);
        req_valid    = 1'b1;
        req_op       = op;
        req_idx      = idx;
        req_src      = src;
        req_src_zero = sz;
        cur_pc       = pc;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_idx = '0; req_src = '0;
        req_src_zero = 1'b0; cur_pc = '0; stall_i = 1'b0; tmr_trap_ena = 1'b0;
        read_csr_data = '0;
        step(); step();
        rst = 1'b0; #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_redir", 64'(redirect_valid), 64'd0);

        // CSRRW 0x340, src 0xA5, old 0x12
        offer(3'd0, 12'h340, 64'hA5, 1'b0, 64'h8000_0000); #1;
        chk("rw_ready", 64'(req_ready), 64'd1);
        step(); req_valid = 1'b0; read_csr_data = 64'h12; #1;
        chk("rw_rd_en", 64'(csr_rd_en), 64'd1);
        chk("rw_rd_idx", 64'(csr_idx), 64'h340);
        chk("rw_busy", 64'(busy), 64'd1);
        chk("rw_c1_wr", 64'(csr_wr_en), 64'd0);
        chk("rw_c1_done", 64'(done), 64'd0);
        step(); read_csr_data = '0; #1;
        chk("rw_wr_en", 64'(csr_wr_en), 64'd1);
        chk("rw_wbck", wbck_csr_data, 64'hA5);
        chk("rw_done", 64'(done), 64'd1);
        chk("rw_rd_data", rd_data, 64'h12);
        chk("rw_c2_rd", 64'(csr_rd_en), 64'd0);
        step(); #1;
        chk("rw_idle_done", 64'(done), 64'd0);
        chk("rw_idle_busy", 64'(busy), 64'd0);

        // CSRRS 0x300 with src_zero: read only
        offer(3'd1, 12'h300, 64'h0, 1'b1, 64'h0);
        step(); req_valid = 1'b0; read_csr_data = 64'h1800; #1;
        chk("rs0_rd_en", 64'(csr_rd_en), 64'd1);
        step(); read_csr_data = '0; #1;
        chk("rs0_wr_en", 64'(csr_wr_en), 64'd0);
        chk("rs0_done", 64'(done), 64'd1);
        chk("rs0_rd_data", rd_data, 64'h1800);

        // CSRRC clears bits: 0xFF & ~0x0F = 0xF0
        step(); offer(3'd2, 12'h344, 64'h0F, 1'b0, 64'h0);
        step(); req_valid = 1'b0; read_csr_data = 64'hFF;
        step(); read_csr_data = '0; #1;
        chk("rc_wr_en", 64'(csr_wr_en), 64'd1);
        chk("rc_wbck", wbck_csr_data, 64'hF0);
        chk("rc_rd_data", rd_data, 64'hFF);

        // ECALL at 0x8000_0010, mtvec 0x8000_0100
        step(); offer(3'd3, 12'h0, 64'h0, 1'b0, 64'h8000_0010);
        step(); req_valid = 1'b0; cur_pc = '0; stall_i = 1'b1; read_csr_data = 64'h8000_0100; #1;
        chk("ec_ena", 64'(ecall_trap_ena), 64'd1);
        chk("ec_wbck", wbck_csr_data, 64'h8000_0010);
        chk("ec_mcause", trap_mcause_value, 64'd11);
        chk("ec_ex_stall", 64'(csr_ex_stall), 64'd0);
        chk("ec_rd_en", 64'(csr_rd_en), 64'd0);
        step(); stall_i = 1'b0; read_csr_data = '0; #1;
        chk("ec_redir_v", 64'(redirect_valid), 64'd1);
        chk("ec_redir_pc", redirect_pc, 64'h8000_0100);
        chk("ec_done", 64'(done), 64'd1);
        chk("ec_ena_off", 64'(ecall_trap_ena), 64'd0);
        step(); #1;
        chk("ec_redir_off", 64'(redirect_valid), 64'd0);

        // MRET with mepc 0x8000_0014
        offer(3'd4, 12'h0, 64'h0, 1'b0, 64'h8000_0020);
        step(); req_valid = 1'b0; read_csr_data = 64'h8000_0014; #1;
        chk("mr_ena", 64'(cmt_mret_ena), 64'd1);
        chk("mr_ecall", 64'(ecall_trap_ena), 64'd0);
        step(); read_csr_data = '0; #1;
        chk("mr_ena_off", 64'(cmt_mret_ena), 64'd0);
        chk("mr_redir_pc", redirect_pc, 64'h8000_0014);
        chk("mr_redir_v", 64'(redirect_valid), 64'd1);

        // Timer beats a same-cycle request, which is then accepted
        step(); offer(3'd0, 12'h341, 64'h77, 1'b0, 64'h8000_0200);
        tmr_trap_ena = 1'b1; read_csr_data = 64'h8000_0100; #1;
        chk("tm_ready", 64'(req_ready), 64'd0);
        chk("tm_mcause", trap_mcause_value, 64'h8000_0000_0000_0007);
        chk("tm_wbck", wbck_csr_data, 64'h8000_0200);
        step(); tmr_trap_ena = 1'b0; read_csr_data = '0; #1;
        chk("tm_redir_pc", redirect_pc, 64'h8000_0100);
        chk("tm_redir_v", 64'(redirect_valid), 64'd1);
        chk("tm_resp_ready", 64'(req_ready), 64'd0);
        step(); #1;
        chk("tm_accept", 64'(req_ready), 64'd1);
        step(); req_valid = 1'b0; read_csr_data = 64'h55; #1;
        chk("tm_rd_en", 64'(csr_rd_en), 64'd1);
        chk("tm_rd_idx", 64'(csr_idx), 64'h341);
        step(); read_csr_data = '0; #1;
        chk("tm_wbck2", wbck_csr_data, 64'h77);
        chk("tm_rd_data", rd_data, 64'h55);

        // Stall in IDLE blocks acceptance and passes through to the CSR stall
        step(); offer(3'd0, 12'h340, 64'h1, 1'b0, 64'h0); stall_i = 1'b1; #1;
        chk("st_ready", 64'(req_ready), 64'd0);
        chk("st_ex_stall", 64'(csr_ex_stall), 64'd1);
        step(); req_valid = 1'b0; stall_i = 1'b0; #1;
        chk("st_busy", 64'(busy), 64'd0);

        // Reserved op 5: done next cycle with no CSR strobes
        offer(3'd5, 12'h340, 64'h1, 1'b0, 64'h0);
        step(); req_valid = 1'b0; #1;
        chk("rsv_done", 64'(done), 64'd1);
        chk("rsv_wr_en", 64'(csr_wr_en), 64'd0);
        chk("rsv_rd_en", 64'(csr_rd_en), 64'd0);
        chk("rsv_rd_data", rd_data, 64'd0);
        step(); #1;
        chk("rsv_idle", 64'(busy), 64'd0);

        // Reset while in CSR_RD drops the op
        offer(3'd0, 12'h340, 64'h99, 1'b0, 64'h0);
        step(); req_valid = 1'b0; rst = 1'b1; read_csr_data = 64'h33; #1;
        chk("rr_rd_en", 64'(csr_rd_en), 64'd1);
        step(); rst = 1'b0; read_csr_data = '0; #1;
        chk("rr_wr_en", 64'(csr_wr_en), 64'd0);
        chk("rr_done", 64'(done), 64'd0);
        chk("rr_busy", 64'(busy), 64'd0);
        chk("rr_rd_data", rd_data, 64'd0);
        chk("rr_idx", 64'(csr_idx), 64'd0);
        chk("rr_wbck", wbck_csr_data, 64'd0);
        step(); #1;
        chk("rr_done2", 64'(done), 64'd0);
        chk("rr_wr_en2", 64'(csr_wr_en), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
